// File: rtl/pipe_ctrl_unit.sv
// rtl/pipe_ctrl_unit.sv - ID decode, hazard/forward control and EX/MEM/WB control pipeline
//
// Purpose: decodes op/func in ID, carries control bits through ID/EX, EX/MEM
// and MEM/WB, detects load-use hazards, selects forwarding sources, raises
// branch/jump flushes and halts on an illegal instruction.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op, func            ID opcode and function field
//   rs, rt, rd          ID register fields
//   rsrtequ             ID compare of forwarded rs/rt operands
//   stall, flush        hold PC and IF/ID / kill instruction in IF
//   pcsource            00 pc+4, 01 branch, 10 jump, 11 trap vector
//   fwda, fwdb          operand source: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load
//   ex_*, mem_*, wb_*   stage control registers
//   halted              sticky illegal-instruction flag

module pipe_ctrl_unit #(
    parameter int AW      = 5,
    parameter int ALUOP_W = 3,
    parameter int EN_FWD  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         op,
    input  logic [5:0]         func,
    input  logic [AW-1:0]      rs,
    input  logic [AW-1:0]      rt,
    input  logic [AW-1:0]      rd,
    input  logic               rsrtequ,
    output logic               stall,
    output logic               flush,
    output logic [1:0]         pcsource,
    output logic [1:0]         fwda,
    output logic [1:0]         fwdb,
    output logic               ex_wreg,
    output logic               ex_sld,
    output logic               ex_wmem,
    output logic               ex_aluimm,
    output logic               ex_shift,
    output logic               ex_sext,
    output logic [ALUOP_W-1:0] ex_aluop,
    output logic [AW-1:0]      ex_rn,
    output logic               mem_wreg,
    output logic               mem_sld,
    output logic               mem_wmem,
    output logic [AW-1:0]      mem_rn,
    output logic               wb_wreg,
    output logic               wb_sld,
    output logic [AW-1:0]      wb_rn,
    output logic               halted
);

    localparam logic [5:0] OP_ADD   = 6'b000000;
    localparam logic [5:0] OP_LOGIC = 6'b000001;
    localparam logic [5:0] OP_SHIFT = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b000101;
    localparam logic [5:0] OP_ANDI  = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001010;
    localparam logic [5:0] OP_XORI  = 6'b001100;
    localparam logic [5:0] OP_LW    = 6'b001101;
    localparam logic [5:0] OP_SW    = 6'b001110;
    localparam logic [5:0] OP_BEQ   = 6'b001111;
    localparam logic [5:0] OP_BNE   = 6'b010000;
    localparam logic [5:0] OP_J     = 6'b010010;

    localparam logic [5:0] F_ADD = 6'b000001;
    localparam logic [5:0] F_AND = 6'b000001;
    localparam logic [5:0] F_OR  = 6'b000010;
    localparam logic [5:0] F_XOR = 6'b000100;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SLL = 6'b000011;

    typedef enum logic {
        S_RUN  = 1'b0,
        S_HALT = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic               r_ex_wreg, r_ex_sld, r_ex_wmem, r_ex_aluimm, r_ex_shift, r_ex_sext;
    logic [ALUOP_W-1:0] r_ex_aluop;
    logic [AW-1:0]      r_ex_rn;
    logic               r_mem_wreg, r_mem_sld, r_mem_wmem;
    logic [AW-1:0]      r_mem_rn;
    logic               r_wb_wreg, r_wb_sld;
    logic [AW-1:0]      r_wb_rn;

    logic               w_legal, w_wreg, w_regrt, w_sld, w_shift, w_aluimm, w_sext, w_wmem;
    logic [2:0]         w_aluop3;
    logic               w_uses_rs, w_uses_rt, w_is_beq, w_is_bne, w_is_j;
    logic [AW-1:0]      w_rn;
    logic               w_wreg_eff;
    logic               w_ex_hit_rs, w_ex_hit_rt, w_mem_hit_rs, w_mem_hit_rt;
    logic               w_loaduse, w_raw, w_hazard, w_bubble;
    logic [1:0]         w_fwda, w_fwdb;

    // Fields are only asserted for a fully matching encoding, so an illegal
    // instruction never claims a source register and cannot trigger a stall.
    always_comb begin
        w_legal   = 1'b0;
        w_wreg    = 1'b0;
        w_regrt   = 1'b0;
        w_sld     = 1'b0;
        w_shift   = 1'b0;
        w_aluimm  = 1'b0;
        w_sext    = 1'b0;
        w_wmem    = 1'b0;
        w_aluop3  = 3'd0;
        w_uses_rs = 1'b0;
        w_uses_rt = 1'b0;
        w_is_beq  = 1'b0;
        w_is_bne  = 1'b0;
        w_is_j    = 1'b0;
        case (op)
            OP_ADD: begin
                if (func == F_ADD) begin
                    w_legal   = 1'b1;
                    w_wreg    = 1'b1;
                    w_uses_rs = 1'b1;
                    w_uses_rt = 1'b1;
                end
            end
            OP_LOGIC: begin
                case (func)
                    F_AND:   begin w_legal = 1'b1; w_aluop3 = 3'd1; end
                    F_OR:    begin w_legal = 1'b1; w_aluop3 = 3'd2; end
                    F_XOR:   begin w_legal = 1'b1; w_aluop3 = 3'd3; end
                    default: ;
                endcase
                w_wreg    = w_legal;
                w_uses_rs = w_legal;
                w_uses_rt = w_legal;
            end
            OP_SHIFT: begin
                case (func)
                    F_SRL:   begin w_legal = 1'b1; w_aluop3 = 3'd4; end
                    F_SLL:   begin w_legal = 1'b1; w_aluop3 = 3'd5; end
                    default: ;
                endcase
                w_wreg    = w_legal;
                w_shift   = w_legal;
                w_uses_rt = w_legal;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: begin
                w_legal   = 1'b1;
                w_wreg    = 1'b1;
                w_regrt   = 1'b1;
                w_aluimm  = 1'b1;
                w_uses_rs = 1'b1;
                w_sext    = (op == OP_ADDI);
                w_aluop3  = (op == OP_ADDI) ? 3'd0 :
                            (op == OP_ANDI) ? 3'd1 :
                            (op == OP_ORI)  ? 3'd2 : 3'd3;
            end
            OP_LW: begin
                w_legal   = 1'b1;
                w_wreg    = 1'b1;
                w_regrt   = 1'b1;
                w_sld     = 1'b1;
                w_aluimm  = 1'b1;
                w_sext    = 1'b1;
                w_uses_rs = 1'b1;
            end
            OP_SW: begin
                w_legal   = 1'b1;
                w_wmem    = 1'b1;
                w_aluimm  = 1'b1;
                w_sext    = 1'b1;
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                w_legal   = 1'b1;
                w_sext    = 1'b1;
                w_aluop3  = 3'd6;
                w_uses_rs = 1'b1;
                w_uses_rt = 1'b1;
                w_is_beq  = (op == OP_BEQ);
                w_is_bne  = (op == OP_BNE);
            end
            OP_J: begin
                w_legal  = 1'b1;
                w_aluop3 = 3'd7;
                w_is_j   = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_rn       = w_regrt ? rt : rd;
    assign w_wreg_eff = w_wreg & (w_rn != '0);

    // Stage registers never hold wreg with rn == 0, but a zero source is
    // excluded explicitly so r0 is never forwarded or waited on.
    assign w_ex_hit_rs  = r_ex_wreg  & (r_ex_rn  == rs) & (rs != '0);
    assign w_ex_hit_rt  = r_ex_wreg  & (r_ex_rn  == rt) & (rt != '0);
    assign w_mem_hit_rs = r_mem_wreg & (r_mem_rn == rs) & (rs != '0);
    assign w_mem_hit_rt = r_mem_wreg & (r_mem_rn == rt) & (rt != '0);

    assign w_loaduse = r_ex_sld & ((w_uses_rs & w_ex_hit_rs) | (w_uses_rt & w_ex_hit_rt));
    assign w_raw     = (w_uses_rs & (w_ex_hit_rs | w_mem_hit_rs)) |
                       (w_uses_rt & (w_ex_hit_rt | w_mem_hit_rt));
    assign w_hazard  = (EN_FWD != 0) ? w_loaduse : w_raw;

    // Nearest producer wins: an EX ALU result shadows anything older in MEM.
    always_comb begin
        w_fwda = 2'b00;
        w_fwdb = 2'b00;
        if (EN_FWD != 0) begin
            if (w_ex_hit_rs & ~r_ex_sld)       w_fwda = 2'b01;
            else if (w_mem_hit_rs & r_mem_sld) w_fwda = 2'b11;
            else if (w_mem_hit_rs)             w_fwda = 2'b10;
            if (w_ex_hit_rt & ~r_ex_sld)       w_fwdb = 2'b01;
            else if (w_mem_hit_rt & r_mem_sld) w_fwdb = 2'b11;
            else if (w_mem_hit_rt)             w_fwdb = 2'b10;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        stall       = 1'b0;
        flush       = 1'b0;
        pcsource    = 2'b00;
        fwda        = w_fwda;
        fwdb        = w_fwdb;
        w_bubble    = 1'b0;
        case (r_state)
            S_RUN: begin
                if (w_hazard) begin
                    // Branch, jump and trap wait for the re-decode.
                    stall    = 1'b1;
                    w_bubble = 1'b1;
                end else if (!w_legal) begin
                    pcsource    = 2'b11;
                    w_bubble    = 1'b1;
                    w_state_nxt = S_HALT;
                end else if ((w_is_beq & rsrtequ) | (w_is_bne & ~rsrtequ)) begin
                    pcsource = 2'b01;
                    flush    = 1'b1;
                end else if (w_is_j) begin
                    pcsource = 2'b10;
                    flush    = 1'b1;
                end
            end
            S_HALT: begin
                stall    = 1'b1;
                w_bubble = 1'b1;
                fwda     = 2'b00;
                fwdb     = 2'b00;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_ex_wreg   <= 1'b0;
            r_ex_sld    <= 1'b0;
            r_ex_wmem   <= 1'b0;
            r_ex_aluimm <= 1'b0;
            r_ex_shift  <= 1'b0;
            r_ex_sext   <= 1'b0;
            r_ex_aluop  <= '0;
            r_ex_rn     <= '0;
            r_mem_wreg  <= 1'b0;
            r_mem_sld   <= 1'b0;
            r_mem_wmem  <= 1'b0;
            r_mem_rn    <= '0;
            r_wb_wreg   <= 1'b0;
            r_wb_sld    <= 1'b0;
            r_wb_rn     <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_bubble) begin
                r_ex_wreg   <= 1'b0;
                r_ex_sld    <= 1'b0;
                r_ex_wmem   <= 1'b0;
                r_ex_aluimm <= 1'b0;
                r_ex_shift  <= 1'b0;
                r_ex_sext   <= 1'b0;
                r_ex_aluop  <= '0;
                r_ex_rn     <= '0;
            end else begin
                r_ex_wreg   <= w_wreg_eff;
                r_ex_sld    <= w_sld;
                r_ex_wmem   <= w_wmem;
                r_ex_aluimm <= w_aluimm;
                r_ex_shift  <= w_shift;
                r_ex_sext   <= w_sext;
                r_ex_aluop  <= ALUOP_W'(w_aluop3);
                r_ex_rn     <= w_rn;
            end
            r_mem_wreg <= r_ex_wreg;
            r_mem_sld  <= r_ex_sld;
            r_mem_wmem <= r_ex_wmem;
            r_mem_rn   <= r_ex_rn;
            r_wb_wreg  <= r_mem_wreg;
            r_wb_sld   <= r_mem_sld;
            r_wb_rn    <= r_mem_rn;
        end
    end

    assign ex_wreg   = r_ex_wreg;
    assign ex_sld    = r_ex_sld;
    assign ex_wmem   = r_ex_wmem;
    assign ex_aluimm = r_ex_aluimm;
    assign ex_shift  = r_ex_shift;
    assign ex_sext   = r_ex_sext;
    assign ex_aluop  = r_ex_aluop;
    assign ex_rn     = r_ex_rn;
    assign mem_wreg  = r_mem_wreg;
    assign mem_sld   = r_mem_sld;
    assign mem_wmem  = r_mem_wmem;
    assign mem_rn    = r_mem_rn;
    assign wb_wreg   = r_wb_wreg;
    assign wb_sld    = r_wb_sld;
    assign wb_rn     = r_wb_rn;
    assign halted    = (r_state == S_HALT);

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb/tb_pipe_ctrl_unit.sv - directed and randomized bench for pipe_ctrl_unit with reference model

module tb_pipe_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = '0, func = '0;
    logic [4:0] rs = '0, rt = '0, rd = '0;
    logic       rsrtequ = 1'b0;
    logic       stall, flush, halted;
    logic [1:0] pcsource, fwda, fwdb;
    logic       ex_wreg, ex_sld, ex_wmem, ex_aluimm, ex_shift, ex_sext;
    logic [2:0] ex_aluop;
    logic [4:0] ex_rn, mem_rn, wb_rn;
    logic       mem_wreg, mem_sld, mem_wmem, wb_wreg, wb_sld;

    pipe_ctrl_unit #(.AW(5), .ALUOP_W(3), .EN_FWD(1)) dut (
        .clk(clk), .rst(rst), .op(op), .func(func), .rs(rs), .rt(rt), .rd(rd),
        .rsrtequ(rsrtequ), .stall(stall), .flush(flush), .pcsource(pcsource),
        .fwda(fwda), .fwdb(fwdb), .ex_wreg(ex_wreg), .ex_sld(ex_sld),
        .ex_wmem(ex_wmem), .ex_aluimm(ex_aluimm), .ex_shift(ex_shift),
        .ex_sext(ex_sext), .ex_aluop(ex_aluop), .ex_rn(ex_rn),
        .mem_wreg(mem_wreg), .mem_sld(mem_sld), .mem_wmem(mem_wmem), .mem_rn(mem_rn),
        .wb_wreg(wb_wreg), .wb_sld(wb_sld), .wb_rn(wb_rn), .halted(halted)
    );

    always #5 clk = ~clk;

    // Instruction table: kind 0 = plain, 1 = beq, 2 = bne, 3 = j.
    typedef struct packed {
        logic [5:0] op;
        logic [5:0] func;
        logic       rtype, wreg, regrt, sld, shift, aluimm, sext, wmem;
        logic [2:0] aluop;
        logic       urs, urt;
        logic [1:0] kind;
    } ent_t;

    typedef struct packed {
        logic       wreg, sld, wmem, aluimm, shift, sext;
        logic [2:0] aluop;
        logic [4:0] rn;
    } ctl_t;

    ent_t tab [15];
    ctl_t m_ex, m_mem, m_wb;
    logic m_halt, m_stall;
    logic last_stall, last_flush;
    logic [1:0] last_pc, last_fwda, last_fwdb;
    int   n_pass = 0, n_total = 0, n_fail = 0;

    function automatic ent_t mk(input int o, input int f, input int rty, input int wr,
                                input int rg, input int sl, input int sh, input int im,
                                input int se, input int wm, input int au, input int us,
                                input int ut, input int kd);
        ent_t e;
        e.op = o[5:0]; e.func = f[5:0]; e.rtype = rty[0]; e.wreg = wr[0];
        e.regrt = rg[0]; e.sld = sl[0]; e.shift = sh[0]; e.aluimm = im[0];
        e.sext = se[0]; e.wmem = wm[0]; e.aluop = au[2:0]; e.urs = us[0];
        e.urt = ut[0]; e.kind = kd[1:0];
        return e;
    endfunction

    function automatic int lookup(input logic [5:0] o, input logic [5:0] f);
        for (int i = 0; i < 15; i++)
            if (tab[i].op == o && (!tab[i].rtype || tab[i].func == f)) return i;
        return -1;
    endfunction

    function automatic logic [1:0] fwd_exp(input logic [4:0] s);
        if (s == 5'd0) return 2'b00;
        if (m_ex.wreg && !m_ex.sld && m_ex.rn == s) return 2'b01;
        if (m_mem.wreg && m_mem.sld && m_mem.rn == s) return 2'b11;
        if (m_mem.wreg && m_mem.rn == s) return 2'b10;
        return 2'b00;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [5:0] o, input logic [5:0] f, input logic [4:0] s,
                        input logic [4:0] t, input logic [4:0] d, input logic eq,
                        input logic r);
        int   k;
        ent_t e;
        ctl_t c;
        logic legal, xs, xf, bub, hrs, hrt;
        logic [1:0] xp, xa, xb;
        logic [4:0] rn;
        @(negedge clk);
        rst = r; op = o; func = f; rs = s; rt = t; rd = d; rsrtequ = eq;
        #1;
        k = lookup(o, f);
        legal = (k >= 0);
        e = legal ? tab[k] : '0;
        rn = e.regrt ? t : d;
        if (m_halt) begin
            xs = 1'b1; xf = 1'b0; xp = 2'b00; xa = 2'b00; xb = 2'b00; bub = 1'b1;
        end else begin
            hrs = e.urs && s != 0 && m_ex.wreg && m_ex.sld && m_ex.rn == s;
            hrt = e.urt && t != 0 && m_ex.wreg && m_ex.sld && m_ex.rn == t;
            xs = hrs || hrt; xf = 1'b0; xp = 2'b00; bub = xs;
            xa = fwd_exp(s); xb = fwd_exp(t);
            if (!xs) begin
                if (!legal) begin xp = 2'b11; bub = 1'b1; end
                else if ((e.kind == 2'd1 && eq) || (e.kind == 2'd2 && !eq)) begin xp = 2'b01; xf = 1'b1; end
                else if (e.kind == 2'd3) begin xp = 2'b10; xf = 1'b1; end
            end
        end
        check("stall", 32'(stall), 32'(xs));
        check("flush", 32'(flush), 32'(xf));
        check("pcsource", 32'(pcsource), 32'(xp));
        check("fwda", 32'(fwda), 32'(xa));
        check("fwdb", 32'(fwdb), 32'(xb));
        check("halted", 32'(halted), 32'(m_halt));
        check("ex_ctl", 32'({ex_wreg, ex_sld, ex_wmem, ex_aluimm, ex_shift, ex_sext, ex_aluop, ex_rn}),
              32'(m_ex));
        check("mem_ctl", 32'({mem_wreg, mem_sld, mem_wmem, mem_rn}),
              32'({m_mem.wreg, m_mem.sld, m_mem.wmem, m_mem.rn}));
        check("wb_ctl", 32'({wb_wreg, wb_sld, wb_rn}), 32'({m_wb.wreg, m_wb.sld, m_wb.rn}));
        last_stall = stall; last_flush = flush; last_pc = pcsource;
        last_fwda = fwda; last_fwdb = fwdb;
        if (r) begin
            m_ex = '0; m_mem = '0; m_wb = '0; m_halt = 1'b0;
        end else begin
            m_wb = m_mem;
            m_mem = m_ex;
            c.wreg = e.wreg && rn != 0; c.sld = e.sld; c.wmem = e.wmem;
            c.aluimm = e.aluimm; c.shift = e.shift; c.sext = e.sext;
            c.aluop = e.aluop; c.rn = rn;
            m_ex = bub ? '0 : c;
            if (!m_halt && !xs && !legal) m_halt = 1'b1;
        end
        m_stall = xs;
        @(posedge clk);
    endtask

    task automatic nop(input logic r);
        step(6'h00, 6'h01, 5'd0, 5'd0, 5'd0, 1'b0, r);
    endtask

    initial begin
        logic [5:0] o, f;
        logic [4:0] s, t, d;
        logic       r;
        int         k;
        tab[0]  = mk(6'h00, 6'h01, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        tab[1]  = mk(6'h01, 6'h01, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
        tab[2]  = mk(6'h01, 6'h02, 1, 1, 0, 0, 0, 0, 0, 0, 2, 1, 1, 0);
        tab[3]  = mk(6'h01, 6'h04, 1, 1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 0);
        tab[4]  = mk(6'h02, 6'h02, 1, 1, 0, 0, 1, 0, 0, 0, 4, 0, 1, 0);
        tab[5]  = mk(6'h02, 6'h03, 1, 1, 0, 0, 1, 0, 0, 0, 5, 0, 1, 0);
        tab[6]  = mk(6'h05, 6'h00, 0, 1, 1, 0, 0, 1, 1, 0, 0, 1, 0, 0);
        tab[7]  = mk(6'h09, 6'h00, 0, 1, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0);
        tab[8]  = mk(6'h0A, 6'h00, 0, 1, 1, 0, 0, 1, 0, 0, 2, 1, 0, 0);
        tab[9]  = mk(6'h0C, 6'h00, 0, 1, 1, 0, 0, 1, 0, 0, 3, 1, 0, 0);
        tab[10] = mk(6'h0D, 6'h00, 0, 1, 1, 1, 0, 1, 1, 0, 0, 1, 0, 0);
        tab[11] = mk(6'h0E, 6'h00, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 0);
        tab[12] = mk(6'h0F, 6'h00, 0, 0, 0, 0, 0, 0, 1, 0, 6, 1, 1, 1);
        tab[13] = mk(6'h10, 6'h00, 0, 0, 0, 0, 0, 0, 1, 0, 6, 1, 1, 2);
        tab[14] = mk(6'h12, 6'h00, 0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 3);
        m_ex = '0; m_mem = '0; m_wb = '0; m_halt = 1'b0; m_stall = 1'b0;

        // Reset, then addi rt=3 walking through the stages.
        nop(1'b1); nop(1'b1);
        #1;
        check("rst_ex_wreg", 32'(ex_wreg), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        step(6'h05, 6'h00, 5'd0, 5'd3, 5'd0, 1'b0, 1'b0);
        #1;
        check("addi_ex", 32'({ex_wreg, ex_aluimm, ex_sext, ex_aluop, ex_rn}), 32'({3'b111, 3'd0, 5'd3}));
        nop(1'b0); #1; check("addi_mem_rn", 32'(mem_rn), 32'd3);
        nop(1'b0); #1; check("addi_wb_rn", 32'(wb_rn), 32'd3);

        // Load-use: lw r5 then add r7 = r5 + r6.
        step(6'h0D, 6'h00, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        step(6'h00, 6'h01, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0);
        check("lu_stall", 32'(last_stall), 32'd1);
        #1; check("lu_bubble", 32'(ex_wreg), 32'd0);
        step(6'h00, 6'h01, 5'd5, 5'd6, 5'd7, 1'b0, 1'b0);
        check("lu_fwda", 32'(last_fwda), 32'd3);
        check("lu_restall", 32'(last_stall), 32'd0);
        #1; check("lu_ex_rn", 32'(ex_rn), 32'd7);

        // EX and MEM forwarding.
        step(6'h00, 6'h01, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        step(6'h01, 6'h04, 5'd4, 5'd4, 5'd8, 1'b0, 1'b0);
        check("fwd_ex", 32'({last_fwda, last_fwdb, last_stall}), 32'({2'b01, 2'b01, 1'b0}));
        step(6'h00, 6'h01, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
        step(6'h05, 6'h00, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0);
        step(6'h01, 6'h04, 5'd4, 5'd4, 5'd8, 1'b0, 1'b0);
        check("fwd_mem", 32'({last_fwda, last_fwdb}), 32'({2'b10, 2'b10}));

        // Branches and jump.
        step(6'h0F, 6'h00, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0);
        check("beq_taken", 32'({last_pc, last_flush}), 32'({2'b01, 1'b1}));
        step(6'h0F, 6'h00, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
        check("beq_not", 32'({last_pc, last_flush}), 32'({2'b00, 1'b0}));
        step(6'h12, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("jump", 32'({last_pc, last_flush}), 32'({2'b10, 1'b1}));

        // Illegal after a pending add r2.
        step(6'h00, 6'h01, 5'd0, 5'd0, 5'd2, 1'b0, 1'b0);
        step(6'h3F, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        check("trap_pc", 32'(last_pc), 32'd3);
        #1; check("halted_set", 32'(halted), 32'd1);
        nop(1'b0);
        check("halt_stall0", 32'(last_stall), 32'd1);
        #1; check("halt_wb", 32'({wb_wreg, wb_rn}), 32'({1'b1, 5'd2}));
        nop(1'b0); check("halt_stall1", 32'(last_stall), 32'd1);
        nop(1'b0); check("halt_stall2", 32'(last_stall), 32'd1);
        nop(1'b1);
        #1; check("halt_clear", 32'(halted), 32'd0);

        // Writes to r0 are dropped and never forwarded.
        step(6'h05, 6'h00, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        #1; check("r0_wreg", 32'(ex_wreg), 32'd0);
        step(6'h00, 6'h01, 5'd0, 5'd0, 5'd3, 1'b0, 1'b0);
        check("r0_fwd", 32'({last_fwda, last_stall}), 32'({2'b00, 1'b0}));

        // Randomized stream; stalled instructions are re-presented.
        o = 6'h00; f = 6'h01; s = '0; t = '0; d = '0;
        for (int i = 0; i < 3000; i++) begin
            if (!m_stall || m_halt) begin
                if ($urandom_range(0, 24) == 0) begin
                    o = 6'($urandom); f = 6'($urandom);
                end else begin
                    k = int'($urandom_range(0, 14));
                    o = tab[k].op;
                    f = tab[k].rtype ? tab[k].func : 6'($urandom);
                end
                s = 5'($urandom_range(0, 7));
                t = 5'($urandom_range(0, 7));
                d = 5'($urandom_range(0, 7));
            end
            r = (m_halt && $urandom_range(0, 3) == 0) || ($urandom_range(0, 199) == 0);
            step(o, f, s, t, d, 1'($urandom), r);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
